// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with a per-register busy scoreboard.
// Sits between decode (read, issue) and writeback (write, scoreboard release).
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_cnt;

  logic             w_wr_en;
  logic             w_iss_en;
  logic             w_inc;
  logic             w_dec;
  logic [DEPTH-1:0] w_busy_next;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign w_wr_en  = we && !((ZERO_REG != 0) && (waddr == '0));
  assign w_iss_en = issue && !((ZERO_REG != 0) && (issue_addr == '0));

  assign w_inc = w_iss_en && !r_busy[issue_addr];
  assign w_dec = w_wr_en && r_busy[waddr] && !(w_iss_en && (issue_addr == waddr));

  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_en)
      w_busy_next[waddr] = 1'b0;
    if (w_iss_en)
      w_busy_next[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_en)
        r_mem[waddr] <= wdata;
      r_busy <= w_busy_next;
      if (w_inc && !w_dec)
        r_cnt <= r_cnt + CNT_ONE;
      else if (w_dec && !w_inc)
        r_cnt <= r_cnt - CNT_ONE;
    end
  end

  function automatic logic [WIDTH-1:0] read_data(input logic [ADDR_W-1:0] ra);
    logic [WIDTH-1:0] v;
    v = r_mem[ra];
    if ((ZERO_REG != 0) && (ra == '0))
      v = '0;
    if ((BYPASS != 0) && w_wr_en && (waddr == ra))
      v = wdata;
    if (!clr)
      v = '0;
    return v;
  endfunction

  // A same-cycle write retires the producer, so the bypassed busy reads clear.
  function automatic logic read_busy(input logic [ADDR_W-1:0] ra);
    logic b;
    b = r_busy[ra];
    if ((BYPASS != 0) && w_wr_en && (waddr == ra))
      b = 1'b0;
    if (!clr)
      b = 1'b0;
    return b;
  endfunction

  assign rdata_a  = read_data(raddr_a);
  assign rdata_b  = read_data(raddr_b);
  assign busy_a   = read_busy(raddr_a);
  assign busy_b   = read_busy(raddr_b);
  assign busy_cnt = r_cnt;

endmodule
